// File: rtl/pipeline_pkg.sv
// Shared pipeline types: mult/div sequencer state, pipeline control bundle, forward-select codes.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bus: ID/EX decode observations in, pipeline control and mult/div status out.
interface hazard_sequencer_if;
  import pipeline_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic [REG_ADDR_W-1:0] id_rt_addr;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_ex_MemRead;
  logic [REG_ADDR_W-1:0] id_ex_write_addr;
  logic                  id_jump;
  logic                  ex_branch_taken;
  logic                  id_md_start;
  logic                  id_md_is_div;
  logic                  id_reads_hilo;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  md_go;
  logic                  md_busy;
  logic                  md_done;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_ex_MemRead, id_ex_write_addr,
           id_jump, ex_branch_taken, id_md_start, id_md_is_div, id_reads_hilo,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, md_go, md_busy, md_done
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_ex_MemRead, id_ex_write_addr,
           id_jump, ex_branch_taken, id_md_start, id_md_is_div, id_reads_hilo,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, md_go, md_busy, md_done
  );

endinterface

// File: rtl/md_latency_counter.sv
// Down-counter timing the mult/div busy window; last flags the final busy cycle.
module md_latency_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_sequencer.sv
// Load-use / HI-LO stall detection, jump and branch flush sequencing, and mult/div busy window.
module hazard_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_sequencer_if.slave hz
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_last;
  logic             load_use;
  logic             md_busy_q;
  logic             md_stall;
  logic             stall;
  logic             md_go_c;
  pipe_ctrl_t       ctrl;

  assign md_busy_q = (state_q == BUSY);

  // Register 0 is never a real producer, so a load into it cannot create a hazard.
  assign load_use = hz.id_ex_MemRead && (hz.id_ex_write_addr != '0) &&
                    ((hz.id_uses_rs && (hz.id_ex_write_addr == hz.id_rs_addr)) ||
                     (hz.id_uses_rt && (hz.id_ex_write_addr == hz.id_rt_addr)));
  assign md_stall = md_busy_q && (hz.id_reads_hilo || hz.id_md_start);
  assign stall    = load_use || md_stall;

  assign cnt_load_value = hz.id_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch beats stall beats jump; a busy operation is never aborted by control flow.
  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_RUN;
    md_go_c = 1'b0;
    if (reset) begin
      state_d = IDLE;
    end else begin
      if (hz.ex_branch_taken) begin
        ctrl = CTRL_BRANCH;
      end else if (stall) begin
        ctrl = CTRL_STALL;
      end else if (hz.id_jump) begin
        ctrl.if_id_flush = 1'b1;
      end
      md_go_c = hz.id_md_start && (state_q == IDLE) && !stall && !hz.ex_branch_taken;
      case (state_q)
        IDLE:    if (md_go_c) state_d = BUSY;
        BUSY:    if (cnt_last || cnt == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  md_latency_counter #(
    .CNT_W (CNT_W)
  ) u_md_latency_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (md_go_c),
    .load_value (cnt_load_value),
    .enable     (md_busy_q),
    .cnt        (cnt),
    .last       (cnt_last)
  );

  assign hz.pc_write    = ctrl.pc_write;
  assign hz.if_id_write = ctrl.if_id_write;
  assign hz.if_id_flush = ctrl.if_id_flush;
  assign hz.id_ex_flush = ctrl.id_ex_flush;
  assign hz.md_go       = md_go_c;
  assign hz.md_busy     = md_busy_q && !reset;
  assign hz.md_done     = md_busy_q && cnt_last && !reset;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: vector table, directed multi-cycle sequences, random vs. reference model.
module tb_hazard_sequencer;

  localparam int unsigned MULT_LAT = 4;
  localparam int unsigned DIV_LAT  = 32;

  // Output vector order: pc_write, if_id_write, if_id_flush, id_ex_flush, md_go, md_busy, md_done
  localparam logic [6:0] O_RUN    = 7'b1100000;
  localparam logic [6:0] O_STALL  = 7'b0001000;
  localparam logic [6:0] O_JUMP   = 7'b1110000;
  localparam logic [6:0] O_BRANCH = 7'b1111000;
  localparam logic [6:0] B_GO     = 7'b0000100;
  localparam logic [6:0] B_BUSY   = 7'b0000010;
  localparam logic [6:0] B_DONE   = 7'b0000001;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       memrd;
    logic [4:0] wa;
    logic       jmp;
    logic       br;
    logic       mds;
    logic       mdiv;
    logic       hilo;
  } in_t;

  typedef struct {
    string      name;
    in_t        i;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   rem      = 0;

  hazard_sequencer_if bus ();

  hazard_sequencer #(
    .MULT_CYCLES (MULT_LAT),
    .DIV_CYCLES  (DIV_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic memrd,
                             input logic [4:0] wa, input logic jmp, input logic br,
                             input logic mds, input logic mdiv, input logic hilo);
    in_t r;
    r.rst = rst; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.memrd = memrd;
    r.wa = wa; r.jmp = jmp; r.br = br; r.mds = mds; r.mdiv = mdiv; r.hilo = hilo;
    return r;
  endfunction

  // Reference: rem = busy cycles still ahead including the current one.
  function automatic logic [6:0] model_out(input in_t i, input int r);
    bit         busy, lu, st, go;
    logic [3:0] c;
    if (i.rst) return O_RUN;
    busy = (r > 0);
    lu   = i.memrd && (i.wa != 5'd0) && ((i.urs && i.wa == i.rs) || (i.urt && i.wa == i.rt));
    st   = lu || (busy && (i.hilo || i.mds));
    if (i.br)       c = 4'b1111;
    else if (st)    c = 4'b0001;
    else if (i.jmp) c = 4'b1110;
    else            c = 4'b1100;
    go = i.mds && !busy && !st && !i.br;
    return {c, go, busy, (r == 1)};
  endfunction

  function automatic int model_next(input in_t i, input int r);
    logic [6:0] o;
    o = model_out(i, r);
    if (i.rst) return 0;
    if (o[2])  return i.mdiv ? int'(DIV_LAT) : int'(MULT_LAT);
    if (r > 0) return r - 1;
    return 0;
  endfunction

  task automatic step(input string nm, input in_t i, input logic [6:0] exp, input bit use_model);
    logic [6:0] got;
    logic [6:0] want;
    @(negedge clk);
    reset                = i.rst;
    bus.id_rs_addr       = i.rs;
    bus.id_rt_addr       = i.rt;
    bus.id_uses_rs       = i.urs;
    bus.id_uses_rt       = i.urt;
    bus.id_ex_MemRead    = i.memrd;
    bus.id_ex_write_addr = i.wa;
    bus.id_jump          = i.jmp;
    bus.ex_branch_taken  = i.br;
    bus.id_md_start      = i.mds;
    bus.id_md_is_div     = i.mdiv;
    bus.id_reads_hilo    = i.hilo;
    #2;
    got  = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
            bus.md_go, bus.md_busy, bus.md_done};
    want = use_model ? model_out(i, rem) : exp;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b (pc,ifw,iff,idf,go,busy,done)", nm, got, want);
    end
    @(posedge clk);
    rem = model_next(i, rem);
  endtask

  vec_t tbl [12];
  in_t  idle_i;
  in_t  cur;

  initial begin
    idle_i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = '{"lu_rs_hit",       mk(0, 8, 3, 1, 1, 1, 8, 0, 0, 0, 0, 0), O_STALL};
    tbl[1]  = '{"lu_released",     mk(0, 8, 3, 1, 1, 0, 8, 0, 0, 0, 0, 0), O_RUN};
    tbl[2]  = '{"lu_addr_zero",    mk(0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0), O_RUN};
    tbl[3]  = '{"lu_rt_hit",       mk(0, 4, 9, 1, 1, 1, 9, 0, 0, 0, 0, 0), O_STALL};
    tbl[4]  = '{"lu_rt_unused",    mk(0, 4, 9, 1, 0, 1, 9, 0, 0, 0, 0, 0), O_RUN};
    tbl[5]  = '{"lu_rs_unused",    mk(0, 9, 4, 0, 1, 1, 9, 0, 0, 0, 0, 0), O_RUN};
    tbl[6]  = '{"jump",            mk(0, 1, 2, 1, 1, 0, 5, 1, 0, 0, 0, 0), O_JUMP};
    tbl[7]  = '{"branch",          mk(0, 1, 2, 1, 1, 0, 5, 0, 1, 0, 0, 0), O_BRANCH};
    tbl[8]  = '{"branch_over_lu",  mk(0, 7, 2, 1, 1, 1, 7, 0, 1, 0, 0, 0), O_BRANCH};
    tbl[9]  = '{"stall_over_jump", mk(0, 7, 2, 1, 1, 1, 7, 1, 0, 0, 0, 0), O_STALL};
    tbl[10] = '{"hilo_idle",       mk(0, 1, 2, 1, 1, 0, 5, 0, 0, 0, 0, 1), O_RUN};
    tbl[11] = '{"reset_forces",    mk(1, 7, 2, 1, 1, 1, 7, 1, 1, 1, 0, 1), O_RUN};

    cur = idle_i; cur.rst = 1'b1;
    step("reset0", cur, O_RUN, 0);
    step("reset1", cur, O_RUN, 0);
    step("post_reset", idle_i, O_RUN, 0);

    foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].exp, 0);

    // mult then mfhi held in ID for the whole busy window
    cur = idle_i; cur.mds = 1'b1;
    step("mult_go", cur, O_RUN | B_GO, 0);
    cur = idle_i; cur.hilo = 1'b1;
    for (int k = 1; k <= int'(MULT_LAT); k++)
      step("mfhi_stall", cur, O_STALL | B_BUSY | ((k == int'(MULT_LAT)) ? B_DONE : 7'b0), 0);
    step("mfhi_proceeds", cur, O_RUN, 0);

    // div in flight; taken branch with mflo in ID does not abort it
    cur = idle_i; cur.mds = 1'b1; cur.mdiv = 1'b1;
    step("div_go", cur, O_RUN | B_GO, 0);
    for (int k = 1; k <= int'(DIV_LAT); k++) begin
      cur = idle_i;
      if (k < 5) cur.hilo = 1'b1;
      if (k == 5) begin cur.hilo = 1'b1; cur.br = 1'b1; end
      step(k == 5 ? "div_branch" : "div_busy", cur,
           ((k < 5) ? O_STALL : (k == 5) ? O_BRANCH : O_RUN) | B_BUSY |
           ((k == int'(DIV_LAT)) ? B_DONE : 7'b0), 0);
    end
    step("div_after", idle_i, O_RUN, 0);

    // reset at busy cycle 2 aborts without a done pulse
    cur = idle_i; cur.mds = 1'b1;
    step("abort_go", cur, O_RUN | B_GO, 0);
    step("abort_busy1", idle_i, O_RUN | B_BUSY, 0);
    cur = idle_i; cur.rst = 1'b1;
    step("abort_reset", cur, O_RUN, 0);
    for (int k = 0; k < 5; k++) step("abort_no_done", idle_i, O_RUN, 0);

    // md_start coinciding with load-use is delayed by one cycle
    cur = mk(0, 6, 0, 1, 0, 1, 6, 0, 0, 1, 0, 0);
    step("md_lu_stall", cur, O_STALL, 0);
    cur.memrd = 1'b0;
    step("md_lu_go", cur, O_RUN | B_GO, 0);
    for (int k = 1; k <= int'(MULT_LAT); k++) begin
      cur = idle_i;
      if (k == int'(MULT_LAT)) cur.mds = 1'b1;
      step("md_lu_busy", cur, (k == int'(MULT_LAT) ? O_STALL | B_DONE : O_RUN) | B_BUSY, 0);
    end
    // md_start on the done cycle issues the following cycle
    cur = idle_i; cur.mds = 1'b1;
    step("b2b_go", cur, O_RUN | B_GO, 0);
    for (int k = 1; k <= int'(MULT_LAT); k++)
      step("b2b_busy", idle_i, O_RUN | B_BUSY | ((k == int'(MULT_LAT)) ? B_DONE : 7'b0), 0);

    for (int n = 0; n < 2000; n++) begin
      cur.rst   = ($urandom_range(0, 63) == 0);
      cur.rs    = 5'($urandom_range(0, 3));
      cur.rt    = 5'($urandom_range(0, 3));
      cur.urs   = 1'($urandom);
      cur.urt   = 1'($urandom);
      cur.memrd = ($urandom_range(0, 2) == 0);
      cur.wa    = 5'($urandom_range(0, 3));
      cur.jmp   = ($urandom_range(0, 7) == 0);
      cur.br    = ($urandom_range(0, 7) == 0);
      cur.mds   = ($urandom_range(0, 5) == 0);
      cur.mdiv  = 1'($urandom);
      cur.hilo  = ($urandom_range(0, 3) == 0);
      step("random", cur, 7'b0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
